// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: phase encodings, default dwell bounds,
// and the legal phase-order table.
package tl_pkg;

    typedef enum logic [2:0] {
        PH_MG   = 3'd0,
        PH_MY   = 3'd1,
        PH_WALK = 3'd2,
        PH_SG   = 3'd3,
        PH_SY   = 3'd4,
        PH_ILL  = 3'd7
    } phase_e;

    localparam int MG_MIN_DEF     = 9;
    localparam int MG_MAX_DEF     = 12;
    localparam int MY_DWELL_DEF   = 2;
    localparam int WALK_DWELL_DEF = 3;
    localparam int SG_MIN_DEF     = 6;
    localparam int SG_MAX_DEF     = 9;
    localparam int SY_DWELL_DEF   = 2;

    // True when 'to' may directly follow 'from' in the controller cycle.
    function automatic logic legal_next(phase_e from, phase_e to);
        logic ok;
        ok = 1'b0;
        case (from)
            PH_MG:   ok = (to == PH_MY);
            PH_MY:   ok = (to == PH_WALK) || (to == PH_SG);
            PH_WALK: ok = (to == PH_SG);
            PH_SG:   ok = (to == PH_SY);
            PH_SY:   ok = (to == PH_MG);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/traffic_light_monitor_if.sv
// Light lines from the controller plus the monitor's status outputs.
// master = whoever drives the lights (controller/bench), slave = monitor.
interface traffic_light_monitor_if;
    logic       tick;
    logic       mainLightR, mainLightY, mainLightG;
    logic       sideLightR, sideLightY, sideLightG;
    logic       walkLight;
    logic       err_clr;
    logic [2:0] phase;
    logic       phase_known;
    logic [3:0] dwell;
    logic [3:0] last_dwell;
    logic       err_conflict;
    logic       err_seq;
    logic       err_dwell;

    modport master (
        output tick, mainLightR, mainLightY, mainLightG,
               sideLightR, sideLightY, sideLightG, walkLight, err_clr,
        input  phase, phase_known, dwell, last_dwell,
               err_conflict, err_seq, err_dwell
    );

    modport slave (
        input  tick, mainLightR, mainLightY, mainLightG,
               sideLightR, sideLightY, sideLightG, walkLight, err_clr,
        output phase, phase_known, dwell, last_dwell,
               err_conflict, err_seq, err_dwell
    );
endinterface

// File: rtl/tl_light_decode.sv
// Combinational lights-to-phase decoder. Any head that is dark or has more
// than one lamp lit, or walk lit with a non-red main/side, decodes as ILL.
module tl_light_decode
    import tl_pkg::*;
(
    input  logic   main_r_i, main_y_i, main_g_i,
    input  logic   side_r_i, side_y_i, side_g_i,
    input  logic   walk_i,
    output phase_e phase_o
);
    logic [2:0] main_w, side_w;

    assign main_w = {main_r_i, main_y_i, main_g_i};
    assign side_w = {side_r_i, side_y_i, side_g_i};

    // Match the five legal lamp patterns exactly; everything else is illegal.
    always_comb begin
        phase_o = PH_ILL;
        if      (main_w == 3'b001 && side_w == 3'b100 && !walk_i) phase_o = PH_MG;
        else if (main_w == 3'b010 && side_w == 3'b100 && !walk_i) phase_o = PH_MY;
        else if (main_w == 3'b100 && side_w == 3'b100 &&  walk_i) phase_o = PH_WALK;
        else if (main_w == 3'b100 && side_w == 3'b001 && !walk_i) phase_o = PH_SG;
        else if (main_w == 3'b100 && side_w == 3'b010 && !walk_i) phase_o = PH_SY;
    end
endmodule

// File: rtl/traffic_light_monitor.sv
// Passive monitor: tracks the decoded phase and its dwell in ticks, and
// raises sticky flags on illegal lamps, illegal order, or bad dwell.
module traffic_light_monitor
    import tl_pkg::*;
#(
    parameter int MG_MIN     = MG_MIN_DEF,
    parameter int MG_MAX     = MG_MAX_DEF,
    parameter int MY_DWELL   = MY_DWELL_DEF,
    parameter int WALK_DWELL = WALK_DWELL_DEF,
    parameter int SG_MIN     = SG_MIN_DEF,
    parameter int SG_MAX     = SG_MAX_DEF,
    parameter int SY_DWELL   = SY_DWELL_DEF
) (
    input logic clk,
    input logic rst,
    traffic_light_monitor_if.slave mon
);
    phase_e     dec;
    phase_e     phase_q, phase_d;
    logic       known_q, known_d;
    logic [3:0] dwell_q, dwell_d;
    logic [3:0] last_q, last_d;
    logic       conf_q, conf_d, seq_q, seq_d, dwl_q, dwl_d;
    logic [3:0] dwell_inc, lo, hi;
    logic       set_conf, set_seq, set_dwl;

    tl_light_decode u_dec (
        .main_r_i (mon.mainLightR), .main_y_i (mon.mainLightY), .main_g_i (mon.mainLightG),
        .side_r_i (mon.sideLightR), .side_y_i (mon.sideLightY), .side_g_i (mon.sideLightG),
        .walk_i   (mon.walkLight),
        .phase_o  (dec)
    );

    // Current count including this cycle's tick, saturating at 15.
    assign dwell_inc = (mon.tick && dwell_q != 4'd15) ? dwell_q + 4'd1 : dwell_q;

    // Dwell window of the phase being left; exact-dwell phases use lo == hi.
    always_comb begin
        lo = 4'd0;
        hi = 4'd15;
        case (phase_q)
            PH_MG:   begin lo = 4'(MG_MIN);     hi = 4'(MG_MAX);     end
            PH_MY:   begin lo = 4'(MY_DWELL);   hi = 4'(MY_DWELL);   end
            PH_WALK: begin lo = 4'(WALK_DWELL); hi = 4'(WALK_DWELL); end
            PH_SG:   begin lo = 4'(SG_MIN);     hi = 4'(SG_MAX);     end
            PH_SY:   begin lo = 4'(SY_DWELL);   hi = 4'(SY_DWELL);   end
            default: begin lo = 4'd0;           hi = 4'd15;          end
        endcase
    end

    // Phase tracking and checks. A phase entered straight from ILL/reset is
    // partial, so only phases whose entry was observed get checked on exit.
    always_comb begin
        phase_d  = phase_q;
        known_d  = known_q;
        dwell_d  = dwell_q;
        last_d   = last_q;
        set_conf = 1'b0;
        set_seq  = 1'b0;
        set_dwl  = 1'b0;
        if (dec == PH_ILL) begin
            phase_d  = PH_ILL;
            known_d  = 1'b0;
            dwell_d  = 4'd0;
            set_conf = 1'b1;
        end else if (dec == phase_q) begin
            dwell_d = dwell_inc;
        end else begin
            phase_d = dec;
            dwell_d = mon.tick ? 4'd1 : 4'd0;
            known_d = (phase_q != PH_ILL);
            if (known_q) begin
                last_d  = dwell_inc;
                set_seq = !legal_next(phase_q, dec);
                set_dwl = (dwell_inc < lo) || (dwell_inc > hi);
            end
        end
        // A same-cycle error event beats err_clr.
        conf_d = (mon.err_clr ? 1'b0 : conf_q) | set_conf;
        seq_d  = (mon.err_clr ? 1'b0 : seq_q)  | set_seq;
        dwl_d  = (mon.err_clr ? 1'b0 : dwl_q)  | set_dwl;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            phase_q <= PH_ILL;
            known_q <= 1'b0;
            dwell_q <= 4'd0;
            last_q  <= 4'd0;
            conf_q  <= 1'b0;
            seq_q   <= 1'b0;
            dwl_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            known_q <= known_d;
            dwell_q <= dwell_d;
            last_q  <= last_d;
            conf_q  <= conf_d;
            seq_q   <= seq_d;
            dwl_q   <= dwl_d;
        end
    end

    assign mon.phase        = phase_q;
    assign mon.phase_known  = known_q;
    assign mon.dwell        = dwell_q;
    assign mon.last_dwell   = last_q;
    assign mon.err_conflict = conf_q;
    assign mon.err_seq      = seq_q;
    assign mon.err_dwell    = dwl_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: drives lamp patterns and ticks,
// compares outputs against hand-computed values.
module tb_traffic_light_monitor;
    import tl_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    traffic_light_monitor_if mif ();

    traffic_light_monitor dut (
        .clk (clk),
        .rst (rst),
        .mon (mif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are read 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lights(input logic [2:0] p);
        {mif.mainLightR, mif.mainLightY, mif.mainLightG} = 3'b100;
        {mif.sideLightR, mif.sideLightY, mif.sideLightG} = 3'b100;
        mif.walkLight = 1'b0;
        case (p)
            3'd0: {mif.mainLightR, mif.mainLightY, mif.mainLightG} = 3'b001;
            3'd1: {mif.mainLightR, mif.mainLightY, mif.mainLightG} = 3'b010;
            3'd2: mif.walkLight = 1'b1;
            3'd3: {mif.sideLightR, mif.sideLightY, mif.sideLightG} = 3'b001;
            3'd4: {mif.sideLightR, mif.sideLightY, mif.sideLightG} = 3'b010;
            default: ;
        endcase
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            mif.tick = 1'b1;
            cyc();
            mif.tick = 1'b0;
        end
    endtask

    task automatic enter(input logic [2:0] p);
        set_lights(p);
        cyc();
    endtask

    task automatic clear_errs();
        mif.err_clr = 1'b1;
        cyc();
        mif.err_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mif.tick = 1'b0;
        mif.err_clr = 1'b0;
        set_lights(3'd0);
        cyc(); cyc();
        checks++; if (mif.phase !== 3'd7) begin errors++; $display("FAIL reset_phase got=%0d exp=7", mif.phase); end
        checks++; if (mif.phase_known !== 1'b0) begin errors++; $display("FAIL reset_known got=%0b exp=0", mif.phase_known); end
        checks++; if (mif.dwell !== 4'd0 || mif.last_dwell !== 4'd0) begin errors++; $display("FAIL reset_dwell got=%0d/%0d exp=0/0", mif.dwell, mif.last_dwell); end
        checks++; if ({mif.err_conflict, mif.err_seq, mif.err_dwell} !== 3'b000) begin errors++; $display("FAIL reset_errs got=%b exp=000", {mif.err_conflict, mif.err_seq, mif.err_dwell}); end
        rst = 1'b1;
    endtask

    task automatic test_legal_cycle();
        enter(3'd0);
        checks++; if (mif.phase !== 3'd0 || mif.phase_known !== 1'b0) begin errors++; $display("FAIL legal_mg phase=%0d known=%0b exp=0/0", mif.phase, mif.phase_known); end
        ticks(12);
        checks++; if (mif.dwell !== 4'd12) begin errors++; $display("FAIL legal_mg_dwell got=%0d exp=12", mif.dwell); end
        enter(3'd1);
        checks++; if (mif.phase !== 3'd1 || mif.phase_known !== 1'b1) begin errors++; $display("FAIL legal_my phase=%0d known=%0b exp=1/1", mif.phase, mif.phase_known); end
        ticks(2);
        enter(3'd3);
        checks++; if (mif.phase !== 3'd3 || mif.last_dwell !== 4'd2) begin errors++; $display("FAIL legal_sg phase=%0d last=%0d exp=3/2", mif.phase, mif.last_dwell); end
        ticks(6);
        enter(3'd4);
        checks++; if (mif.phase !== 3'd4 || mif.last_dwell !== 4'd6) begin errors++; $display("FAIL legal_sy phase=%0d last=%0d exp=4/6", mif.phase, mif.last_dwell); end
        ticks(2);
        enter(3'd0);
        checks++; if (mif.phase !== 3'd0 || mif.last_dwell !== 4'd2) begin errors++; $display("FAIL legal_mg2 phase=%0d last=%0d exp=0/2", mif.phase, mif.last_dwell); end
        checks++; if ({mif.err_conflict, mif.err_seq, mif.err_dwell} !== 3'b000) begin errors++; $display("FAIL legal_errs got=%b exp=000", {mif.err_conflict, mif.err_seq, mif.err_dwell}); end
    endtask

    task automatic test_walk_cycle();
        ticks(10);
        enter(3'd1);
        checks++; if (mif.last_dwell !== 4'd10) begin errors++; $display("FAIL walk_mg_last got=%0d exp=10", mif.last_dwell); end
        ticks(2);
        enter(3'd2);
        checks++; if (mif.phase !== 3'd2) begin errors++; $display("FAIL walk_phase got=%0d exp=2", mif.phase); end
        ticks(3);
        enter(3'd3);
        checks++; if (mif.last_dwell !== 4'd3) begin errors++; $display("FAIL walk_last got=%0d exp=3", mif.last_dwell); end
        ticks(9);
        enter(3'd4);
        checks++; if (mif.last_dwell !== 4'd9) begin errors++; $display("FAIL walk_sg_last got=%0d exp=9", mif.last_dwell); end
        ticks(2);
        enter(3'd0);
        checks++; if ({mif.err_conflict, mif.err_seq, mif.err_dwell} !== 3'b000) begin errors++; $display("FAIL walk_errs got=%b exp=000", {mif.err_conflict, mif.err_seq, mif.err_dwell}); end
    endtask

    task automatic test_conflict();
        set_lights(3'd0);
        mif.sideLightG = 1'b1;
        cyc();
        checks++; if (mif.err_conflict !== 1'b1 || mif.phase !== 3'd7 || mif.phase_known !== 1'b0) begin errors++; $display("FAIL conflict got=%0b/%0d/%0b exp=1/7/0", mif.err_conflict, mif.phase, mif.phase_known); end
        checks++; if (mif.dwell !== 4'd0) begin errors++; $display("FAIL conflict_dwell got=%0d exp=0", mif.dwell); end
        enter(3'd0);
        ticks(10);
        enter(3'd1);
        checks++; if (mif.err_seq !== 1'b0 || mif.err_dwell !== 1'b0 || mif.phase_known !== 1'b1) begin errors++; $display("FAIL conflict_after seq=%0b dwl=%0b known=%0b exp=0/0/1", mif.err_seq, mif.err_dwell, mif.phase_known); end
        clear_errs();
        checks++; if (mif.err_conflict !== 1'b0) begin errors++; $display("FAIL conflict_clr got=%0b exp=0", mif.err_conflict); end
    endtask

    task automatic test_bad_sequence();
        ticks(2); enter(3'd3);
        ticks(6); enter(3'd4);
        ticks(2); enter(3'd0);
        ticks(10);
        enter(3'd3);
        checks++; if (mif.err_seq !== 1'b1 || mif.err_dwell !== 1'b0) begin errors++; $display("FAIL bad_seq seq=%0b dwl=%0b exp=1/0", mif.err_seq, mif.err_dwell); end
        clear_errs();
        checks++; if ({mif.err_conflict, mif.err_seq, mif.err_dwell} !== 3'b000) begin errors++; $display("FAIL bad_seq_clr got=%b exp=000", {mif.err_conflict, mif.err_seq, mif.err_dwell}); end
        // clear and conflict in the same cycle: the set wins
        set_lights(3'd7);
        mif.err_clr = 1'b1;
        cyc();
        mif.err_clr = 1'b0;
        checks++; if (mif.err_conflict !== 1'b1) begin errors++; $display("FAIL clr_vs_set got=%0b exp=1", mif.err_conflict); end
        clear_errs();
    endtask

    task automatic test_dwell();
        enter(3'd3); ticks(6);
        enter(3'd4); ticks(2);
        enter(3'd0); ticks(9);
        enter(3'd1);
        checks++; if (mif.err_dwell !== 1'b0 || mif.last_dwell !== 4'd9) begin errors++; $display("FAIL dwell_min dwl=%0b last=%0d exp=0/9", mif.err_dwell, mif.last_dwell); end
        ticks(3);
        enter(3'd3);
        checks++; if (mif.err_dwell !== 1'b1 || mif.last_dwell !== 4'd3 || mif.err_seq !== 1'b0) begin errors++; $display("FAIL dwell_my dwl=%0b last=%0d seq=%0b exp=1/3/0", mif.err_dwell, mif.last_dwell, mif.err_seq); end
        clear_errs();
        // tick coincident with the transition counts toward the old phase
        ticks(5);
        set_lights(3'd4);
        mif.tick = 1'b1;
        cyc();
        mif.tick = 1'b0;
        checks++; if (mif.last_dwell !== 4'd6 || mif.dwell !== 4'd1 || mif.err_dwell !== 1'b0) begin errors++; $display("FAIL dwell_tick last=%0d dwell=%0d dwl=%0b exp=6/1/0", mif.last_dwell, mif.dwell, mif.err_dwell); end
        ticks(1);
        enter(3'd0);
        ticks(20);
        checks++; if (mif.dwell !== 4'd15) begin errors++; $display("FAIL dwell_sat got=%0d exp=15", mif.dwell); end
        enter(3'd1);
        checks++; if (mif.last_dwell !== 4'd15 || mif.err_dwell !== 1'b1) begin errors++; $display("FAIL dwell_sat_last last=%0d dwl=%0b exp=15/1", mif.last_dwell, mif.err_dwell); end
        clear_errs();
    endtask

    task automatic test_mid_reset();
        ticks(2);
        enter(3'd3);
        ticks(4);
        checks++; if (mif.dwell !== 4'd4) begin errors++; $display("FAIL midrst_pre got=%0d exp=4", mif.dwell); end
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        checks++; if (mif.phase !== 3'd7 || mif.dwell !== 4'd0 || mif.phase_known !== 1'b0 || mif.last_dwell !== 4'd0) begin errors++; $display("FAIL midrst phase=%0d dwell=%0d known=%0b last=%0d exp=7/0/0/0", mif.phase, mif.dwell, mif.phase_known, mif.last_dwell); end
        checks++; if ({mif.err_conflict, mif.err_seq, mif.err_dwell} !== 3'b000) begin errors++; $display("FAIL midrst_errs got=%b exp=000", {mif.err_conflict, mif.err_seq, mif.err_dwell}); end
        cyc();
        ticks(2);
        enter(3'd4);
        checks++; if (mif.phase !== 3'd4 || mif.err_dwell !== 1'b0 || mif.last_dwell !== 4'd0 || mif.phase_known !== 1'b1) begin errors++; $display("FAIL midrst_sy phase=%0d dwl=%0b last=%0d known=%0b exp=4/0/0/1", mif.phase, mif.err_dwell, mif.last_dwell, mif.phase_known); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_legal_cycle();
        test_walk_cycle();
        test_conflict();
        test_bad_sequence();
        test_dwell();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
